// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, response and external-ALU signals of the ALU sequencer.
interface alu_sequencer_if #(parameter int size = 8);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [size-1:0] cmd_a;
    logic [size-1:0] cmd_b;
    logic            cmd_cin;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [size-1:0] rsp_data;
    logic [size-1:0] alu_a;
    logic [size-1:0] alu_b;
    logic            alu_cin;
    logic [5:0]      alu_sel;
    logic [size-1:0] alu_y;
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready, alu_y,
        input  cmd_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_cin, alu_sel
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready, alu_y,
        output cmd_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_cin, alu_sel
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences single ops and shift-add multiply through an external combinational ALU.
module alu_sequencer #(parameter int size = 8) (
    input  logic          clk,
    input  logic          rst_n,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, MUL_ADD, MUL_SHF, DONE} state_t;
    localparam int cw = $clog2(size) + 1;
    localparam logic [5:0] sel_tab [8] = '{6'b010001, 6'b010101, 6'b011000, 6'b011001,
                                          6'b011010, 6'b110000, 6'b000000, 6'b010000};
    state_t state, nxt;
    logic [2:0] op;
    logic cin;
    logic [size-1:0] acc, mcand, mplier, data;
    logic [cw-1:0] cnt;
    logic accept, last;
    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign last = cnt == cw'(size - 1);
    assign bus.rsp_data = data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = (bus.cmd_op == 3'd7) ? MUL_ADD : EXEC;
            EXEC:    nxt = DONE;
            MUL_ADD: nxt = MUL_SHF;
            MUL_SHF: nxt = last ? DONE : MUL_ADD;
            DONE:    if (bus.rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        bus.cmd_ready = (state == IDLE) && rst_n;
        bus.rsp_valid = state == DONE;
        // mcand/mplier double as the A/B operand registers for single-cycle ops
        bus.alu_a = (state == EXEC || state == MUL_SHF) ? mcand : (state == MUL_ADD) ? acc : '0;
        bus.alu_b = (state == EXEC) ? mplier : (state == MUL_ADD) ? mcand : '0;
        bus.alu_cin = (state == EXEC) && (op[2:1] == 2'b00) && cin;
        bus.alu_sel = (state == EXEC) ? sel_tab[op] :
                      (state == MUL_ADD) ? (mplier[0] ? 6'b010100 : 6'b010000) :
                      (state == MUL_SHF) ? 6'b110000 : 6'b010000;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op <= '0;
            cin <= 1'b0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            data <= '0;
        end else if (accept) begin
            op <= bus.cmd_op;
            cin <= bus.cmd_cin;
            mcand <= bus.cmd_a;
            mplier <= bus.cmd_b;
            acc <= '0;
            cnt <= '0;
        end else if (state == EXEC) begin
            data <= bus.alu_y;
        end else if (state == MUL_ADD) begin
            acc <= bus.alu_y;
            mplier <= mplier >> 1;
        end else if (state == MUL_SHF) begin
            mcand <= bus.alu_y;
            cnt <= cnt + 1'b1;
            if (last) data <= acc;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed tests of alu_sequencer against a behavioural model of the external ALU.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int passed = 0;
    int total = 0;
    logic [7:0] core;
    alu_sequencer_if #(.size(8)) bus ();
    alu_sequencer #(.size(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // External ALU: [3] selects logic vs arith, [5:4] applies an optional 1-bit shift
    always_comb begin
        if (bus.alu_sel[3])
            core = (bus.alu_sel[2:0] == 3'b000) ? (bus.alu_a & bus.alu_b) :
                   (bus.alu_sel[2:0] == 3'b001) ? (bus.alu_a | bus.alu_b) :
                   (bus.alu_sel[2:0] == 3'b010) ? (bus.alu_a ^ bus.alu_b) : bus.alu_a;
        else
            core = (bus.alu_sel[2:0] == 3'b001 || bus.alu_sel[2:0] == 3'b100) ?
                       bus.alu_a + bus.alu_b + {7'b0, bus.alu_cin} :
                   (bus.alu_sel[2:0] == 3'b101) ? bus.alu_a - bus.alu_b - {7'b0, bus.alu_cin} : bus.alu_a;
        bus.alu_y = (bus.alu_sel[5:4] == 2'b00) ? core >> 1 :
                    (bus.alu_sel[5:4] == 2'b11) ? core << 1 : core;
    end

    task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int lat, output logic [7:0] data, output logic [5:0] sel0);
        int w = 0;
        while (!bus.cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_cin = c; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd2; bus.cmd_a = ~a; bus.cmd_b = ~b; bus.cmd_cin = ~c;
        sel0 = bus.alu_sel;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        data = bus.rsp_data;
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.cmd_ready !== 1'b0) $display("FAIL reset cmd_ready got %b want 0", bus.cmd_ready); else passed++;
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset rsp_valid got %b want 0", bus.rsp_valid); else passed++;
        total++; if (bus.rsp_data !== 8'h00) $display("FAIL reset rsp_data got %h want 00", bus.rsp_data); else passed++;
        total++; if (bus.alu_sel !== 6'b010000) $display("FAIL reset alu_sel got %b want 010000", bus.alu_sel); else passed++;
        total++; if ({bus.alu_a, bus.alu_b, bus.alu_cin} !== 17'h0) $display("FAIL reset alu_abc got %h/%h/%b want 0", bus.alu_a, bus.alu_b, bus.alu_cin); else passed++;
        rst_n = 1'b1;
        #1;
        total++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_release cmd_ready got %b want 1", bus.cmd_ready); else passed++;
    endtask

    task automatic test_single(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic [7:0] exp, input logic [5:0] exp_sel);
        int lat;
        logic [7:0] d;
        logic [5:0] s;
        run(op, a, b, c, lat, d, s);
        total++; if (s !== exp_sel) $display("FAIL %s alu_sel got %b want %b", name, s, exp_sel); else passed++;
        total++; if (lat !== 1) $display("FAIL %s latency got %0d want 1", name, lat); else passed++;
        total++; if (d !== exp) $display("FAIL %s rsp_data got %h want %h", name, d, exp); else passed++;
        ack();
        total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) $display("FAIL %s post_ack valid/ready got %b/%b want 0/1", name, bus.rsp_valid, bus.cmd_ready); else passed++;
    endtask

    task automatic test_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp, input logic [5:0] exp_sel);
        int lat;
        logic [7:0] d;
        logic [5:0] s;
        run(3'd7, a, b, 1'b0, lat, d, s);
        total++; if (s !== exp_sel) $display("FAIL %s first alu_sel got %b want %b", name, s, exp_sel); else passed++;
        total++; if (lat !== 16) $display("FAIL %s latency got %0d want 16", name, lat); else passed++;
        total++; if (d !== exp) $display("FAIL %s rsp_data got %h want %h", name, d, exp); else passed++;
        ack();
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [7:0] d;
        logic [5:0] s;
        run(3'd0, 8'h10, 8'h20, 1'b0, lat, d, s);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h01; end
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h30) $display("FAIL stall%0d valid/data got %b/%h want 1/30", i, bus.rsp_valid, bus.rsp_data); else passed++;
            total++; if (bus.cmd_ready !== 1'b0) $display("FAIL stall%0d cmd_ready got %b want 0", i, bus.cmd_ready); else passed++;
        end
        ack();
        @(posedge clk); #1;
        total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) $display("FAIL stall_ignored valid/ready got %b/%b want 0/1", bus.rsp_valid, bus.cmd_ready); else passed++;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        logic [7:0] d;
        logic [5:0] s;
        bus.cmd_op = 3'd7; bus.cmd_a = 8'h0D; bus.cmd_b = 8'h0B; bus.cmd_cin = 1'b0; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL midrst ready/valid got %b/%b want 0/0", bus.cmd_ready, bus.rsp_valid); else passed++;
        total++; if (bus.rsp_data !== 8'h00) $display("FAIL midrst rsp_data got %h want 00", bus.rsp_data); else passed++;
        total++; if ({bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin} !== {6'b010000, 17'h0}) $display("FAIL midrst alu got %b/%h/%h/%b want 010000/00/00/0", bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL midrst_release ready/valid got %b/%b want 1/0", bus.cmd_ready, bus.rsp_valid); else passed++;
        run(3'd0, 8'h01, 8'h01, 1'b0, lat, d, s);
        total++; if (lat !== 1 || d !== 8'h02) $display("FAIL midrst_add lat/data got %0d/%h want 1/02", lat, d); else passed++;
        ack();
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_cin = 1'b0; bus.rsp_ready = 1'b0;
        test_reset();
        test_single("add", 3'd0, 8'h7F, 8'h01, 1'b1, 8'h81, 6'b010001);
        test_single("sub", 3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 6'b010101);
        test_single("and", 3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 6'b011000);
        test_single("or",  3'd3, 8'hA0, 8'h05, 1'b1, 8'hA5, 6'b011001);
        test_single("xor", 3'd4, 8'hFF, 8'h0F, 1'b0, 8'hF0, 6'b011010);
        test_single("shl", 3'd5, 8'h81, 8'h00, 1'b1, 8'h02, 6'b110000);
        test_single("shr", 3'd6, 8'h81, 8'h00, 1'b1, 8'h40, 6'b000000);
        test_mul("mul_0d_0b", 8'h0D, 8'h0B, 8'h8F, 6'b010100);
        test_mul("mul_20_10", 8'h20, 8'h10, 8'h00, 6'b010000);
        test_mul("mul_55_00", 8'h55, 8'h00, 8'h00, 6'b010000);
        test_back_pressure();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
